lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store unit between the core's MEM stage and the word-only data memory (dmem, either type).
//  Turns LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
//  Loads: extracts the addressed byte or half and sign/zero-extends it.
//  Sub-word stores: read-modify-write. Word stores: a single write.
//  Handles dmem read latency for both memory types.
// PARAMETERS
//  MEMORY_TYPE  0  dmem read latency: 0 = combinational (synth RAM), 1 = one cycle (BSRAM)
// PORTS
//  clk         in   1   clock
//  reset       in   1   asynchronous, active-high reset
//  req_valid   in   1   core request valid
//  req_ready   out  1   LSU can accept a request (high only in IDLE)
//  req_we      in   1   1 = store, 0 = load
//  req_funct3  in   3   RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data (B/H taken from low bits)
//  resp_valid  out  1   one-cycle pulse: request complete
//  resp_rdata  out  32  extended load data (0 for stores)
//  resp_err    out  1   request faulted (only with LSU_MISALIGN_TRAP_EN; else tied 0)
//  mem_a       out  32  dmem word index = {2'b0, addr[31:2]}
//  mem_we      out  1   dmem write enable
//  mem_wd      out  32  dmem write data
//  mem_rd      in   32  dmem read data
// BEHAVIOUR
//  - Handshake:
//    - Accept on posedge with req_valid && req_ready; addr/we/funct3/wdata are latched.
//    - No response back-pressure.
//  - FSM states: IDLE, RD, RD_WAIT, WR, RESP.
//    - IDLE -accept-> RD (load or sub-word store) | WR (SW).
//    - RD -> RD_WAIT if MEMORY_TYPE=1; otherwise capture mem_rd, then RESP (load) or WR (store).
//    - RD_WAIT: capture mem_rd -> RESP | WR.
//    - WR: mem_we=1 for exactly one cycle -> RESP.
//    - RESP: resp_valid=1 for one cycle -> IDLE.
//  - Latency from the accept edge, in cycles to RESP:
//    - LW/LB: 2 (type 0), 3 (type 1).
//    - SW: 2.
//    - SB/SH: 3 (type 0), 4 (type 1).
//  - mem_a is driven in RD, RD_WAIT and WR; 0 otherwise.
//  - mem_wd is 0 outside WR.
//    - SW: wdata.
//    - SB: old word with byte lane addr[1:0] replaced by wdata[7:0].
//    - SH: old word with half lane addr[1] replaced by wdata[15:0].
//  - Loads:
//    - B/H are extracted from lane addr[1:0] / addr[1].
//    - B/H sign-extend; BU/HU zero-extend.
//  - Alignment without the macro:
//    - Low address bits below the access size are ignored (H uses addr[1]; W ignores [1:0]).
//    - funct3 011/110/111 is handled as W.
//  - Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_a=0, mem_wd=0.
//  - Reset during WR aborts the write: mem_we is decoded from state, so it falls with reset.
//    RMW atomicity is not guaranteed across reset.
//  - A new request in the RESP cycle is not accepted (req_ready=0). Earliest re-accept: the IDLE cycle after RESP.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//    - An H access with addr[0]=1, a W access with addr[1:0]!=0, or an illegal funct3 goes IDLE -> RESP.
//    - No memory access is made; resp_err=1, resp_rdata=0.
//  LSU_MISALIGN_TRAP_EN undefined:
//    - Silent alignment as above; resp_err held 0; no error logic is synthesized.
// STRUCTURE
//  - lsu_pkg holds:
//    - lsu_state_t enum;
//    - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU;
//    - function is_misaligned(funct3, addr[1:0]).
//  - One sub-module, lsu_align (combinational):
//    - inputs: funct3, addr[1:0], old word, wdata, rdata;
//    - outputs: merged store word and extended load word.
//  - lsu holds the FSM, request latch and capture register.
// TESTING (run for MEMORY_TYPE 0 and 1)
//  1. SW 0x11223344 @0x4, then LW @0x4 -> mem_we one cycle with mem_a=1; resp_rdata=0x11223344; latency as specified.
//  2. SB 0xAB @0x6 over 0x11223344 -> RD then WR; mem_wd=0x11AB3344; following LW @0x4 = 0x11AB3344.
//  3. LB / LBU / LH @0x6 on 0x11AB3344 -> 0xFFFFFFAB / 0x000000AB / 0x000011AB.
//  4. SH 0x8001 @0x2 on 0 -> word 0x80010000; LH @0x2 = 0xFFFF8001; LHU = 0x00008001.
//  5. Assert reset in WR of an SB -> mem_we drops immediately; outputs at reset values; memory word unchanged.
//  6. With macro: LW @0x5 -> RESP next cycle, resp_err=1, mem_we never high. Without macro: LW @0x5 reads word 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   lsu_state_t     : FSM state encoding (IDLE, RD, RD_WAIT, WR, RESP)
//   F3_*            : RISC-V funct3 encodings for the supported access sizes
//   is_misaligned() : 1 when an H access has addr[0]=1 or a W access has addr[1:0]!=0
//   is_illegal_f3() : 1 for funct3 codes the unit does not implement
// The helpers are only consulted when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Stores only exist as SB/SH/SW; the unsigned codes are load-only.
    function automatic logic is_illegal_f3(input logic we, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return we;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Inputs : funct3, addr_lo (addr[1:0]), old_word (word read for RMW),
//          wdata (store data), rdata (word read for a load)
// Outputs: st_word (word to write back), ld_word (extended load result)
// Size is taken from funct3[1:0] (00 byte, 01 half, anything else word) and
// signedness from funct3[2], so 011/110/111 behave as plain word accesses.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] st_word,
    output logic [31:0] ld_word
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Half accesses use only addr[1]; addr[0] is ignored.
    assign byte_sh = {addr_lo, 3'b000};
    assign half_sh = {addr_lo[1], 4'b0000};

    always_comb begin
        st_word = wdata;
        ld_word = rdata;
        ld_byte = 8'(rdata >> byte_sh);
        ld_half = 16'(rdata >> half_sh);
        case (funct3[1:0])
            2'b00: begin
                st_word = (old_word & ~(32'h0000_00FF << byte_sh))
                        | ({24'd0, wdata[7:0]} << byte_sh);
                ld_word = funct3[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            2'b01: begin
                st_word = (old_word & ~(32'h0000_FFFF << half_sh))
                        | ({16'd0, wdata[15:0]} << half_sh);
                ld_word = funct3[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: begin
                st_word = wdata;
                ld_word = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the core MEM stage and a word-only data memory.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake; ready is high only in IDLE
//   req_we, req_funct3          store flag and RISC-V access size/sign code
//   req_addr, req_wdata         byte address and store data
//   resp_valid                  one-cycle completion pulse (no back-pressure)
//   resp_rdata, resp_err        extended load data (0 for stores), fault flag
//   mem_a, mem_we, mem_wd       word index, write enable, write data to dmem
//   mem_rd                      read data from dmem
// Parameter MEMORY_TYPE: 0 = combinational dmem read, 1 = one-cycle read.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses and illegal
// funct3 codes complete at once with resp_err=1 and no memory access.
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high; all request fields are latched on that edge.
module lsu
    import lsu_pkg::*;
#(
    parameter int MEMORY_TYPE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_t  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] st_word;
    logic [31:0] ld_word;
    logic        resp_zero;
    logic        req_is_word;

    // Word-size stores need no read; any code whose low bits are not 00/01 is word.
    assign req_is_word = (req_funct3[1:0] != 2'b00) && (req_funct3[1:0] != 2'b01);

    lsu_align u_align (
        .funct3   (f3_q),
        .addr_lo  (addr_q[1:0]),
        .old_word (word_q),
        .wdata    (wdata_q),
        .rdata    (word_q),
        .st_word  (st_word),
        .ld_word  (ld_word)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q, err_d;
    logic req_trap;

    assign req_trap  = is_misaligned(req_funct3, req_addr[1:0]) || is_illegal_f3(req_we, req_funct3);
    assign resp_err  = (state_q == ST_RESP) && err_q;
    assign resp_zero = we_q || err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
`else
    assign resp_err  = 1'b0;
    assign resp_zero = we_q;
`endif

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
`ifdef LSU_MISALIGN_TRAP_EN
        err_d      = err_q;
`endif
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        mem_a      = 32'd0;
        mem_we     = 1'b0;
        mem_wd     = 32'd0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                    err_d   = req_trap;
                    if (req_trap)                    state_d = ST_RESP;
                    else if (req_we && req_is_word)  state_d = ST_WR;
                    else                             state_d = ST_RD;
`else
                    if (req_we && req_is_word)       state_d = ST_WR;
                    else                             state_d = ST_RD;
`endif
                end
            end
            ST_RD: begin
                mem_a = {2'b00, addr_q[31:2]};
                if (MEMORY_TYPE == 1) begin
                    state_d = ST_RD_WAIT;
                end else begin
                    word_d  = mem_rd;
                    state_d = we_q ? ST_WR : ST_RESP;
                end
            end
            ST_RD_WAIT: begin
                mem_a   = {2'b00, addr_q[31:2]};
                word_d  = mem_rd;
                state_d = we_q ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                // Decoded from state so an asynchronous reset drops it at once.
                mem_a   = {2'b00, addr_q[31:2]};
                mem_we  = 1'b1;
                mem_wd  = st_word;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = resp_zero ? 32'd0 : ld_word;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            word_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: one instance per memory type, driven with the same requests.
// Each instance has its own dmem model and its own expected queues; a monitor
// pops and compares responses and writes as they appear.
module tb_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_ready0, resp_valid0, resp_err0, mem_we0;
    logic [31:0] resp_rdata0, mem_a0, mem_wd0, mem_rd0;
    logic        req_ready1, resp_valid1, resp_err1, mem_we1;
    logic [31:0] resp_rdata1, mem_a1, mem_wd1, mem_rd1;

    lsu #(.MEMORY_TYPE(0)) u_dut0 (
        .clk(clk), .reset(rst0), .req_valid(req_valid), .req_ready(req_ready0),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
        .mem_a(mem_a0), .mem_we(mem_we0), .mem_wd(mem_wd0), .mem_rd(mem_rd0)
    );

    lsu #(.MEMORY_TYPE(1)) u_dut1 (
        .clk(clk), .reset(rst1), .req_valid(req_valid), .req_ready(req_ready1),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
        .mem_a(mem_a1), .mem_we(mem_we1), .mem_wd(mem_wd1), .mem_rd(mem_rd1)
    );

    // dmem models: type 0 reads combinationally, type 1 registers the read.
    logic [31:0] mem0 [16] = '{default: 32'd0};
    logic [31:0] mem1 [16] = '{default: 32'd0};
    assign mem_rd0 = mem0[mem_a0[3:0]];
    always @(posedge clk) begin
        if (mem_we0) mem0[mem_a0[3:0]] <= mem_wd0;
        if (mem_we1) mem1[mem_a1[3:0]] <= mem_wd1;
        mem_rd1 <= mem1[mem_a1[3:0]];
    end

    // Scoreboard: response entries are {latency[3:0], err, rdata}; writes are {mem_a, mem_wd}.
    logic [36:0] exp0_q[$];
    logic [36:0] exp1_q[$];
    logic [63:0] wr0_q[$];
    logic [63:0] wr1_q[$];
    int checks = 0;
    int errors = 0;
    int cyc0 = 0;
    int cyc1 = 0;
    bit abort_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    task automatic mon(input int id, input logic rst, input logic rv, input logic rdy,
                       input logic [31:0] rdata, input logic err, input logic we,
                       input logic [31:0] a, input logic [31:0] wd, input int cyc);
        logic [36:0] e;
        logic [63:0] w;
        bit have;
        if (rst) return;
        if (rv) begin
            have = (id == 0) ? (exp0_q.size() != 0) : (exp1_q.size() != 0);
            if (!have) begin
                fail_evt($sformatf("resp%0d_unexpected", id));
            end else begin
                if (id == 0) e = exp0_q.pop_front();
                else         e = exp1_q.pop_front();
                chk($sformatf("resp%0d_rdata", id), rdata, e[31:0]);
                chk($sformatf("resp%0d_err", id), {31'd0, err}, {31'd0, e[32]});
                chk($sformatf("resp%0d_latency", id), cyc, {28'd0, e[36:33]});
                chk($sformatf("resp%0d_ready_low", id), {31'd0, rdy}, 32'd0);
            end
        end
        if (we && !abort_mode) begin
            have = (id == 0) ? (wr0_q.size() != 0) : (wr1_q.size() != 0);
            if (!have) begin
                fail_evt($sformatf("mem%0d_we_unexpected", id));
            end else begin
                if (id == 0) w = wr0_q.pop_front();
                else         w = wr1_q.pop_front();
                chk($sformatf("mem%0d_a", id), a, w[63:32]);
                chk($sformatf("mem%0d_wd", id), wd, w[31:0]);
            end
        end
    endtask

    // Monitor: latency counters restart on the accept edge and are read half a cycle later.
    always begin
        @(posedge clk);
        if (req_valid && req_ready0 && !rst0) cyc0 = 0;
        if (req_valid && req_ready1 && !rst1) cyc1 = 0;
        @(negedge clk);
        cyc0++;
        cyc1++;
        mon(0, rst0, resp_valid0, req_ready0, resp_rdata0, resp_err0, mem_we0, mem_a0, mem_wd0, cyc0);
        mon(1, rst1, resp_valid1, req_ready1, resp_rdata1, resp_err1, mem_we1, mem_a1, mem_wd1, cyc1);
    end

    task automatic chk_reset_outputs(input int id);
        if (id == 0) begin
            chk("rst0_flags", {28'd0, req_ready0, resp_valid0, resp_err0, mem_we0}, 32'h8);
            chk("rst0_rdata", resp_rdata0, 32'd0);
            chk("rst0_mem_a", mem_a0, 32'd0);
            chk("rst0_mem_wd", mem_wd0, 32'd0);
        end else begin
            chk("rst1_flags", {28'd0, req_ready1, resp_valid1, resp_err1, mem_we1}, 32'h8);
            chk("rst1_rdata", resp_rdata1, 32'd0);
            chk("rst1_mem_a", mem_a1, 32'd0);
            chk("rst1_mem_wd", mem_wd1, 32'd0);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(req_ready0 && req_ready1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_evt("timeout_idle");
    endtask

    // Issue one request to both units, then wait for both responses.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                         input int lat0, input int lat1, input logic wr, input logic [31:0] wr_word);
        int n = 0;
        wait_idle();
        exp0_q.push_back({4'(lat0), exp_err, exp_rd});
        exp1_q.push_back({4'(lat1), exp_err, exp_rd});
        if (wr) begin
            wr0_q.push_back({{2'b00, addr[31:2]}, wr_word});
            wr1_q.push_back({{2'b00, addr[31:2]}, wr_word});
        end
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            fail_evt("timeout_resp");
            exp0_q.delete();
            exp1_q.delete();
        end
        @(negedge clk);
    endtask

    // Reset each unit on the cycle it presents its write; the write must not land.
    task automatic abort_store();
        bit done0 = 1'b0;
        bit done1 = 1'b0;
        bit we0s, we1s;
        wait_idle();
        abort_mode = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h4;
        req_wdata  = 32'h0000_00CC;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        for (int n = 0; n < 10 && !(done0 && done1); n++) begin
            @(negedge clk);
            we0s = mem_we0;
            we1s = mem_we1;
            if (we0s && !done0) rst0 = 1'b1;
            if (we1s && !done1) rst1 = 1'b1;
            #1;
            if (we0s && !done0) begin chk_reset_outputs(0); done0 = 1'b1; end
            if (we1s && !done1) begin chk_reset_outputs(1); done1 = 1'b1; end
        end
        if (!(done0 && done1)) fail_evt("timeout_abort");
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        abort_mode = 1'b0;
        chk("abort_mem0_word1", mem0[1], 32'h80AB_3344);
        chk("abort_mem1_word1", mem1[1], 32'h80AB_3344);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);

        // SW then LW of the same word.
        issue(1'b1, 3'b010, 32'h4, 32'h1122_3344, 32'd0, 1'b0, 2, 2, 1'b1, 32'h1122_3344);
        issue(1'b0, 3'b010, 32'h4, 32'd0, 32'h1122_3344, 1'b0, 2, 3, 1'b0, 32'd0);
        // SB read-modify-write; upper wdata bits must be ignored.
        issue(1'b1, 3'b000, 32'h6, 32'hFFFF_FFAB, 32'd0, 1'b0, 3, 4, 1'b1, 32'h11AB_3344);
        issue(1'b0, 3'b010, 32'h4, 32'd0, 32'h11AB_3344, 1'b0, 2, 3, 1'b0, 32'd0);
        // Byte/half extraction and extension.
        issue(1'b0, 3'b000, 32'h6, 32'd0, 32'hFFFF_FFAB, 1'b0, 2, 3, 1'b0, 32'd0);
        issue(1'b0, 3'b100, 32'h6, 32'd0, 32'h0000_00AB, 1'b0, 2, 3, 1'b0, 32'd0);
        issue(1'b0, 3'b001, 32'h6, 32'd0, 32'h0000_11AB, 1'b0, 2, 3, 1'b0, 32'd0);
        issue(1'b0, 3'b000, 32'h4, 32'd0, 32'h0000_0044, 1'b0, 2, 3, 1'b0, 32'd0);
        issue(1'b0, 3'b100, 32'h7, 32'd0, 32'h0000_0011, 1'b0, 2, 3, 1'b0, 32'd0);
        // SH into an all-zero word, then signed/unsigned half reads.
        issue(1'b1, 3'b001, 32'h2, 32'hFFFF_8001, 32'd0, 1'b0, 3, 4, 1'b1, 32'h8001_0000);
        issue(1'b0, 3'b001, 32'h2, 32'd0, 32'hFFFF_8001, 1'b0, 2, 3, 1'b0, 32'd0);
        issue(1'b0, 3'b101, 32'h2, 32'd0, 32'h0000_8001, 1'b0, 2, 3, 1'b0, 32'd0);
        issue(1'b0, 3'b010, 32'h0, 32'd0, 32'h8001_0000, 1'b0, 2, 3, 1'b0, 32'd0);
        // Misaligned and illegal-code accesses.
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 32'h5, 32'd0, 32'd0, 1'b1, 1, 1, 1'b0, 32'd0);
        issue(1'b0, 3'b011, 32'h4, 32'd0, 32'd0, 1'b1, 1, 1, 1'b0, 32'd0);
        issue(1'b0, 3'b001, 32'h3, 32'd0, 32'd0, 1'b1, 1, 1, 1'b0, 32'd0);
        issue(1'b1, 3'b010, 32'h5, 32'h1234_5678, 32'd0, 1'b1, 1, 1, 1'b0, 32'd0);
`else
        issue(1'b0, 3'b010, 32'h5, 32'd0, 32'h11AB_3344, 1'b0, 2, 3, 1'b0, 32'd0);
        issue(1'b0, 3'b011, 32'h4, 32'd0, 32'h11AB_3344, 1'b0, 2, 3, 1'b0, 32'd0);
        issue(1'b0, 3'b001, 32'h3, 32'd0, 32'hFFFF_8001, 1'b0, 2, 3, 1'b0, 32'd0);
`endif
        // Top byte lane store and signed read back.
        issue(1'b1, 3'b000, 32'h7, 32'h0000_0080, 32'd0, 1'b0, 3, 4, 1'b1, 32'h80AB_3344);
        issue(1'b0, 3'b000, 32'h7, 32'd0, 32'hFFFF_FF80, 1'b0, 2, 3, 1'b0, 32'd0);
        // Reset in the write cycle of an SB, then confirm the word is intact.
        abort_store();
        issue(1'b0, 3'b010, 32'h4, 32'd0, 32'h80AB_3344, 1'b0, 2, 3, 1'b0, 32'd0);

        repeat (4) @(negedge clk);
        chk("wr0_left", wr0_q.size(), 32'd0);
        chk("wr1_left", wr1_q.size(), 32'd0);
        chk("exp0_left", exp0_q.size(), 32'd0);
        chk("exp1_left", exp1_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
